// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: four extension modes, one registered output stage
// backed by a single skid entry, with a sideband tag carried alongside each result.
module imm_ext_pipe #(
   parameter int unsigned IN_W     = 16,
   parameter int unsigned OUT_W    = 32,
   parameter int unsigned BR_SHIFT = 2,
   parameter int unsigned TAG_W    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  imm_in,
   input  logic [1:0]       mode,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] imm_out,
   output logic [TAG_W-1:0] out_tag
);

   if (OUT_W < IN_W + BR_SHIFT) begin : g_bad_params
      $error("imm_ext_pipe: OUT_W must be >= IN_W + BR_SHIFT");
   end

   typedef enum logic [1:0] {
      EMPTY,
      HALF,
      FULL
   } state_t;

   state_t           state_q, state_d;
   logic [OUT_W-1:0] m_data_q, m_data_d;
   logic [TAG_W-1:0] m_tag_q, m_tag_d;
   logic [OUT_W-1:0] s_data_q, s_data_d;
   logic [TAG_W-1:0] s_tag_q, s_tag_d;

   logic [OUT_W-1:0] zext, sext, ext;
   logic             accept, pop;

   assign zext = OUT_W'(imm_in);
   assign sext = OUT_W'($signed(imm_in));

   always_comb begin
      ext = zext;
      unique case (mode)
         2'd0: ext = zext;
         2'd1: ext = sext;
         2'd2: ext = zext << (OUT_W - IN_W);
         2'd3: ext = sext << BR_SHIFT;
         default: ext = zext;
      endcase
   end

   // Handshake flags depend on state only, so out_ready never reaches in_ready.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign imm_out   = m_data_q;
   assign out_tag   = m_tag_q;

   always_comb begin
      state_d  = state_q;
      m_data_d = m_data_q;
      m_tag_d  = m_tag_q;
      s_data_d = s_data_q;
      s_tag_d  = s_tag_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d  = HALF;
               m_data_d = ext;
               m_tag_d  = tag_in;
            end
         end
         HALF: begin
            if (accept && !pop) begin
               state_d  = FULL;
               s_data_d = ext;
               s_tag_d  = tag_in;
            end else if (pop && !accept) begin
               state_d = EMPTY;
            end else if (accept && pop) begin
               m_data_d = ext;
               m_tag_d  = tag_in;
            end
         end
         FULL: begin
            if (pop) begin
               state_d  = HALF;
               m_data_d = s_data_q;
               m_tag_d  = s_tag_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         m_data_q <= '0;
         m_tag_q  <= '0;
         s_data_q <= '0;
         s_tag_q  <= '0;
      end else begin
         state_q  <= state_d;
         m_data_q <= m_data_d;
         m_tag_q  <= m_tag_d;
         s_data_q <= s_data_d;
         s_tag_q  <= s_tag_d;
      end
   end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed and soak bench for imm_ext_pipe at default parameters (16 -> 32, shift 2, tag 5).
module tb_imm_ext_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] imm_in;
   logic [1:0]  mode;
   logic [4:0]  tag_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] imm_out;
   logic [4:0]  out_tag;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   imm_ext_pipe #(
      .IN_W    (16),
      .OUT_W   (32),
      .BR_SHIFT(2),
      .TAG_W   (5)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .imm_in   (imm_in),
      .mode     (mode),
      .tag_in   (tag_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .imm_out  (imm_out),
      .out_tag  (out_tag)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_ext(input logic [15:0] v, input logic [1:0] m);
      case (m)
         2'd0:    ref_ext = {16'h0000, v};
         2'd1:    ref_ext = {{16{v[15]}}, v};
         2'd2:    ref_ext = {v, 16'h0000};
         default: ref_ext = {{14{v[15]}}, v, 2'b00};
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] i, input logic [1:0] m, input logic [4:0] t);
      in_valid = v;
      imm_in   = i;
      mode     = m;
      tag_in   = t;
   endtask

   logic [36:0] sb[$];
   logic [15:0] r_imm;
   logic [1:0]  r_mode;
   logic [31:0] exp_d;
   logic        acc, pp;

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 16'h0, 2'd0, 5'd0);

      // reset state
      tick();
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
      chk("rst_in_ready",  64'(in_ready),  64'(1'b1));
      chk("rst_imm_out",   64'(imm_out),   64'h0);
      chk("rst_out_tag",   64'(out_tag),   64'h0);

      // one-cycle latency, all modes, streaming with out_ready=1
      rst_n     = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 16'h8000, 2'd0, 5'd3);
      tick();
      chk("m0_valid", 64'(out_valid), 64'(1'b1));
      chk("m0_data",  64'(imm_out),   64'h0000_8000);
      chk("m0_tag",   64'(out_tag),   64'd3);
      drive(1'b1, 16'h8000, 2'd1, 5'd4);
      tick();
      chk("m1_data",  64'(imm_out),   64'hFFFF_8000);
      chk("m1_tag",   64'(out_tag),   64'd4);
      drive(1'b1, 16'h1234, 2'd2, 5'd5);
      tick();
      chk("m2_data",  64'(imm_out),   64'h1234_0000);
      chk("m2_tag",   64'(out_tag),   64'd5);
      drive(1'b1, 16'hFFFF, 2'd3, 5'd6);
      tick();
      chk("m3_neg_data", 64'(imm_out), 64'hFFFF_FFFC);
      drive(1'b1, 16'h0001, 2'd3, 5'd7);
      tick();
      chk("m3_pos_data", 64'(imm_out), 64'h0000_0004);
      chk("m3_pos_tag",  64'(out_tag), 64'd7);
      chk("stream_in_ready", 64'(in_ready), 64'(1'b1));
      drive(1'b0, 16'h0, 2'd0, 5'd0);
      tick();
      chk("drain_valid", 64'(out_valid), 64'(1'b0));

      // backpressure: fill main + skid, third held, then drain in order
      out_ready = 1'b0;
      drive(1'b1, 16'h0011, 2'd0, 5'd1);
      tick();
      chk("bp1_in_ready", 64'(in_ready), 64'(1'b1));
      chk("bp1_tag",      64'(out_tag),  64'd1);
      drive(1'b1, 16'h0022, 2'd0, 5'd2);
      tick();
      chk("bp2_in_ready", 64'(in_ready), 64'(1'b0));
      chk("bp2_tag",      64'(out_tag),  64'd1);
      drive(1'b1, 16'h0033, 2'd0, 5'd3);
      tick();
      chk("bp3_stable_tag",  64'(out_tag), 64'd1);
      chk("bp3_stable_data", 64'(imm_out), 64'h0000_0011);
      chk("bp3_in_ready",    64'(in_ready), 64'(1'b0));
      out_ready = 1'b1;
      tick();
      chk("dr1_tag",      64'(out_tag),  64'd2);
      chk("dr1_data",     64'(imm_out),  64'h0000_0022);
      chk("dr1_in_ready", 64'(in_ready), 64'(1'b1));
      tick();
      chk("dr2_tag",  64'(out_tag), 64'd3);
      chk("dr2_data", 64'(imm_out), 64'h0000_0033);
      drive(1'b0, 16'h0, 2'd0, 5'd0);
      tick();
      chk("dr3_valid", 64'(out_valid), 64'(1'b0));

      // full throughput: 20 results in 20 cycles
      for (int i = 0; i < 20; i++) begin
         r_imm  = 16'($urandom);
         r_mode = 2'($urandom_range(3));
         exp_d  = ref_ext(r_imm, r_mode);
         drive(1'b1, r_imm, r_mode, 5'(i));
         tick();
         chk("tp_valid",    64'(out_valid), 64'(1'b1));
         chk("tp_in_ready", 64'(in_ready),  64'(1'b1));
         chk("tp_data",     64'(imm_out),   64'(exp_d));
         chk("tp_tag",      64'(out_tag),   64'(i));
      end
      drive(1'b0, 16'h0, 2'd0, 5'd0);
      tick();
      chk("tp_drain_valid", 64'(out_valid), 64'(1'b0));

      // reset while FULL discards both entries
      out_ready = 1'b0;
      drive(1'b1, 16'hAAAA, 2'd1, 5'd9);
      tick();
      drive(1'b1, 16'h5555, 2'd2, 5'd10);
      tick();
      chk("full_in_ready", 64'(in_ready), 64'(1'b0));
      rst_n     = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("frst_valid",    64'(out_valid), 64'(1'b0));
      chk("frst_in_ready", 64'(in_ready),  64'(1'b1));
      chk("frst_data",     64'(imm_out),   64'h0);
      chk("frst_tag",      64'(out_tag),   64'h0);
      rst_n = 1'b1;
      drive(1'b0, 16'h0, 2'd0, 5'd0);
      tick();
      chk("frst_after_valid", 64'(out_valid), 64'(1'b0));

      // random soak against an ordered scoreboard
      for (int c = 0; c < 10000; c++) begin
         r_imm  = 16'($urandom);
         r_mode = 2'($urandom_range(3));
         drive(1'($urandom), r_imm, r_mode, 5'($urandom));
         out_ready = 1'($urandom);
         chk("soak_valid",    64'(out_valid), 64'(sb.size() != 0));
         chk("soak_in_ready", 64'(in_ready),  64'(sb.size() < 2));
         if (sb.size() != 0)
            chk("soak_result", 64'({out_tag, imm_out}), 64'(sb[0]));
         acc = in_valid && (sb.size() < 2);
         pp  = out_ready && (sb.size() != 0);
         tick();
         if (pp)  void'(sb.pop_front());
         if (acc) sb.push_back({tag_in, ref_ext(r_imm, r_mode)});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
